// File: rtl/qbert_rom_loader_if.sv
// ---------------------------------------------------------------------------
// qbert_rom_loader_if
// Purpose : HPS download (ioctl) bus between the HPS bridge and the Q*bert
//           ROM loader.
// Signals : ioctl_download  transfer in progress
//           ioctl_index     transfer index (loader accepts index 0 only)
//           ioctl_wr        one-cycle byte-valid strobe
//           ioctl_addr      byte address of ioctl_dout
//           ioctl_dout      download byte
//           ioctl_wait      backpressure from the loader
// Modports: master = HPS side (drives the transfer), slave = loader side.
// ---------------------------------------------------------------------------
interface qbert_rom_loader_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;

  modport master (
    output ioctl_download,
    output ioctl_index,
    output ioctl_wr,
    output ioctl_addr,
    output ioctl_dout,
    input  ioctl_wait
  );

  modport slave (
    input  ioctl_download,
    input  ioctl_index,
    input  ioctl_wr,
    input  ioctl_addr,
    input  ioctl_dout,
    output ioctl_wait
  );
endinterface

// File: rtl/qbert_rom_loader.sv
// ---------------------------------------------------------------------------
// qbert_rom_loader
// Purpose : Receives the Q*bert ROM image from the HPS download bus, splits
//           it into the four ROM regions (main CPU, tiles, sprites, sound),
//           issues held write strobes, and validates the image length (and
//           optionally its checksum) before releasing the game boards.
// Ports   : clk_sys        system clock (only clock)
//           reset_n        asynchronous active-low reset
//           ioctl          HPS download bus (slave modport)
//           rom_addr       region-relative write address
//           rom_data       write data
//           rom_we         one-hot write enables [0]cpu [1]tiles [2]sprites
//                          [3]sound; zero outside the WRITE state
//           game_reset_n   low holds video/sound boards in reset
//           load_done      sticky: last load succeeded
//           load_error     sticky: last load failed
//           checksum       modulo-256 sum of accepted bytes
// Config  : define QBERT_LOADER_CHECKSUM_EN to also require checksum == 0
//           when the image is checked.
// ---------------------------------------------------------------------------
module qbert_rom_loader #(
  parameter int WR_HOLD       = 2,
  parameter int EXPECTED_SIZE = 94208
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  qbert_rom_loader_if.slave ioctl,
  output logic [15:0]       rom_addr,
  output logic [7:0]        rom_data,
  output logic [3:0]        rom_we,
  output logic              game_reset_n,
  output logic              load_done,
  output logic              load_error,
  output logic [7:0]        checksum
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_t;

  // Write-enable for the region containing byte address a; zero past the image.
  function automatic logic [3:0] region_we(input logic [24:0] a);
    logic [3:0] we;
    if (a < 25'h0_6000) begin
      we = 4'b0001;
    end else if (a < 25'h0_E000) begin
      we = 4'b0010;
    end else if (a < 25'h1_6000) begin
      we = 4'b0100;
    end else if (a < 25'h1_7000) begin
      we = 4'b1000;
    end else begin
      we = 4'b0000;
    end
    return we;
  endfunction

  // Low 16 bits of the region base; subtracting it from the low 16 address
  // bits gives the same result as a full-width subtract truncated to 16 bits.
  function automatic logic [15:0] region_base(input logic [24:0] a);
    logic [15:0] base;
    if (a < 25'h0_6000) begin
      base = 16'h0000;
    end else if (a < 25'h0_E000) begin
      base = 16'h6000;
    end else if (a < 25'h1_6000) begin
      base = 16'hE000;
    end else if (a < 25'h1_7000) begin
      base = 16'h6000;
    end else begin
      base = 16'h7000;
    end
    return base;
  endfunction

  state_t      state_r, state_nxt_s;
  logic        dl_prev_r;
  logic [2:0]  hold_r, hold_nxt_s;
  logic [16:0] cnt_r, cnt_nxt_s;
  logic [7:0]  sum_r, sum_nxt_s;
  logic        wait_r, wait_nxt_s;
  logic [15:0] addr_r, addr_nxt_s;
  logic [7:0]  data_r, data_nxt_s;
  logic [3:0]  we_r, we_nxt_s;
  logic        done_r, done_nxt_s;
  logic        err_r, err_nxt_s;
  logic        grn_r, grn_nxt_s;
  logic        idx_ok_s;
  logic        arm_s;
  logic        accept_s;
  logic        pass_s;

  // Only a rising edge of download re-arms, so a level held through reset
  // release is not mistaken for a new transfer (dl_prev_r resets high).
  assign idx_ok_s = (ioctl.ioctl_index == 8'h00);
  assign arm_s    = ioctl.ioctl_download & ~dl_prev_r & idx_ok_s;
  assign accept_s = ioctl.ioctl_download & ioctl.ioctl_wr & idx_ok_s;

`ifdef QBERT_LOADER_CHECKSUM_EN
  assign pass_s = (cnt_r == 17'(EXPECTED_SIZE)) && (sum_r == 8'h00);
`else
  assign pass_s = (cnt_r == 17'(EXPECTED_SIZE));
`endif

  // FSM state register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (arm_s) begin
          state_nxt_s = ST_ARMED;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (!ioctl.ioctl_download) begin
          state_nxt_s = ST_CHECK;
        end else if (accept_s) begin
          state_nxt_s = ST_WRITE;
        end else begin
          state_nxt_s = ST_ARMED;
        end
      end
      ST_WRITE: begin
        // A download that ended mid-write is noticed once the strobe is done.
        if (hold_r != 3'd0) begin
          state_nxt_s = ST_WRITE;
        end else if (ioctl.ioctl_download) begin
          state_nxt_s = ST_ARMED;
        end else begin
          state_nxt_s = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (pass_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_ERROR;
        end
      end
      ST_DONE:  state_nxt_s = ST_IDLE;
      ST_ERROR: state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output/datapath next values; every output is registered below.
  always_comb begin
    hold_nxt_s = hold_r;
    cnt_nxt_s  = cnt_r;
    sum_nxt_s  = sum_r;
    wait_nxt_s = wait_r;
    addr_nxt_s = addr_r;
    data_nxt_s = data_r;
    we_nxt_s   = we_r;
    done_nxt_s = done_r;
    err_nxt_s  = err_r;
    grn_nxt_s  = grn_r;
    case (state_r)
      ST_IDLE: begin
        if (arm_s) begin
          cnt_nxt_s  = 17'd0;
          sum_nxt_s  = 8'h00;
          done_nxt_s = 1'b0;
          err_nxt_s  = 1'b0;
          grn_nxt_s  = 1'b0;
        end else begin
          cnt_nxt_s  = cnt_r;
        end
      end
      ST_ARMED: begin
        if (accept_s) begin
          addr_nxt_s = ioctl.ioctl_addr[15:0] - region_base(ioctl.ioctl_addr);
          data_nxt_s = ioctl.ioctl_dout;
          we_nxt_s   = region_we(ioctl.ioctl_addr);
          wait_nxt_s = 1'b1;
          hold_nxt_s = 3'(WR_HOLD - 1);
          cnt_nxt_s  = (cnt_r == 17'h1_FFFF) ? cnt_r : (cnt_r + 17'd1);
          sum_nxt_s  = sum_r + ioctl.ioctl_dout;
        end else begin
          we_nxt_s   = 4'b0000;
        end
      end
      ST_WRITE: begin
        if (hold_r == 3'd0) begin
          we_nxt_s   = 4'b0000;
          wait_nxt_s = 1'b0;
        end else begin
          hold_nxt_s = hold_r - 3'd1;
        end
      end
      ST_CHECK: begin
        if (pass_s) begin
          done_nxt_s = 1'b1;
          grn_nxt_s  = 1'b1;
        end else begin
          err_nxt_s  = 1'b1;
          grn_nxt_s  = 1'b0;
        end
      end
      ST_DONE:  we_nxt_s = 4'b0000;
      ST_ERROR: we_nxt_s = 4'b0000;
      default:  we_nxt_s = 4'b0000;
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dl_prev_r <= 1'b1;
      hold_r    <= 3'd0;
      cnt_r     <= 17'd0;
      sum_r     <= 8'h00;
      wait_r    <= 1'b0;
      addr_r    <= 16'h0000;
      data_r    <= 8'h00;
      we_r      <= 4'b0000;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      grn_r     <= 1'b0;
    end else begin
      dl_prev_r <= ioctl.ioctl_download;
      hold_r    <= hold_nxt_s;
      cnt_r     <= cnt_nxt_s;
      sum_r     <= sum_nxt_s;
      wait_r    <= wait_nxt_s;
      addr_r    <= addr_nxt_s;
      data_r    <= data_nxt_s;
      we_r      <= we_nxt_s;
      done_r    <= done_nxt_s;
      err_r     <= err_nxt_s;
      grn_r     <= grn_nxt_s;
    end
  end

  assign ioctl.ioctl_wait = wait_r;
  assign rom_addr         = addr_r;
  assign rom_data         = data_r;
  assign rom_we           = we_r;
  assign game_reset_n     = grn_r;
  assign load_done        = done_r;
  assign load_error       = err_r;
  assign checksum         = sum_r;

endmodule

// File: tb/tb_qbert_rom_loader.sv
// ---------------------------------------------------------------------------
// tb_qbert_rom_loader
// Directed bench for qbert_rom_loader with a shortened image (24 bytes) so a
// full load fits in a short run. Region boundaries are exercised with a fixed
// address table; a pad byte sets the image checksum to a chosen value.
// ---------------------------------------------------------------------------
module tb_qbert_rom_loader;
  localparam int HOLD = 2;
  localparam int NBYTES = 24;

  logic        clk;
  logic        reset_n;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic [3:0]  rom_we;
  logic        game_reset_n;
  logic        load_done;
  logic        load_error;
  logic [7:0]  checksum;

  qbert_rom_loader_if ifc ();

  qbert_rom_loader #(.WR_HOLD(HOLD), .EXPECTED_SIZE(NBYTES)) dut (
    .clk_sys      (clk),
    .reset_n      (reset_n),
    .ioctl        (ifc),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .rom_we       (rom_we),
    .game_reset_n (game_reset_n),
    .load_done    (load_done),
    .load_error   (load_error),
    .checksum     (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int exp_pulses = 0;
  logic [7:0] model_sum;

  // Region-boundary table: address, expected enable, expected relative address
  logic [24:0] tbl_addr [0:7] = '{25'h00000, 25'h05FFF, 25'h06000, 25'h0DFFF,
                                  25'h0E000, 25'h15FFF, 25'h16000, 25'h16FFF};
  logic [3:0]  tbl_we   [0:7] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010,
                                  4'b0100, 4'b0100, 4'b1000, 4'b1000};
  logic [15:0] tbl_rel  [0:7] = '{16'h0000, 16'h5FFF, 16'h0000, 16'h7FFF,
                                  16'h0000, 16'h7FFF, 16'h0000, 16'h0FFF};

  // Write-pulse monitor: counts pulses, captures first-cycle values,
  // flags wrong pulse lengths and unstable/non-one-hot pulses.
  int         run = 0;
  int         pulses = 0;
  int         bad_len = 0;
  int         unstable = 0;
  logic [3:0]  cap_we = 4'b0000;
  logic [15:0] cap_addr = 16'h0000;
  logic [7:0]  cap_data = 8'h00;

  always @(negedge clk) begin
    if (rom_we != 4'b0000) begin
      if (run == 0) begin
        cap_we   <= rom_we;
        cap_addr <= rom_addr;
        cap_data <= rom_data;
      end else if (rom_we != cap_we || rom_addr != cap_addr || rom_data != cap_data) begin
        unstable <= unstable + 1;
      end
      if (!$onehot(rom_we)) unstable <= unstable + 1;
      run <= run + 1;
    end else if (run != 0) begin
      pulses <= pulses + 1;
      if (run != HOLD) bad_len <= bad_len + 1;
      run <= 0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input bit drop);
    int g;
    g = 0;
    while (ifc.ioctl_wait && g < 50) begin
      tick(1);
      g++;
    end
    check_eq("wait_low_before_wr", 32'(ifc.ioctl_wait), 32'd0);
    ifc.ioctl_addr = a;
    ifc.ioctl_dout = d;
    ifc.ioctl_wr   = 1'b1;
    tick(1);
    ifc.ioctl_wr = 1'b0;
    if (drop) ifc.ioctl_download = 1'b0;
    check_eq("wait_high_in_write", 32'(ifc.ioctl_wait), 32'd1);
    model_sum = model_sum + d;
    if (a < 25'h17000) exp_pulses++;
    tick(HOLD + 1);
  endtask

  task automatic start_load();
    ifc.ioctl_index    = 8'h00;
    ifc.ioctl_download = 1'b1;
    model_sum = 8'h00;
    tick(2);
  endtask

  task automatic wait_status();
    int g;
    g = 0;
    while (!(load_done || load_error) && g < 20) begin
      tick(1);
      g++;
    end
    check_eq("status_bound", 32'(load_done | load_error), 32'd1);
  endtask

  // NBYTES-byte image: boundary table, filler, then a pad byte making the
  // running sum equal to target.
  task automatic full_image(input logic [7:0] target, input bit drop_last);
    for (int i = 0; i < 8; i++) begin
      send_byte(tbl_addr[i], 8'(i * 17 + 3), 1'b0);
      check_eq("region_we", 32'(cap_we), 32'(tbl_we[i]));
      check_eq("region_addr", 32'(cap_addr), 32'(tbl_rel[i]));
      check_eq("region_data", 32'(cap_data), 32'(8'(i * 17 + 3)));
    end
    for (int i = 0; i < NBYTES - 9; i++) begin
      send_byte(25'h00100 + 25'(i), 8'(i * 7 + 1), 1'b0);
    end
    send_byte(25'h00200, target - model_sum, drop_last);
  endtask

  initial begin
    reset_n            = 1'b0;
    ifc.ioctl_download = 1'b0;
    ifc.ioctl_index    = 8'h00;
    ifc.ioctl_wr       = 1'b0;
    ifc.ioctl_addr     = 25'h0;
    ifc.ioctl_dout     = 8'h00;
    model_sum          = 8'h00;
    tick(3);

    // Reset state
    check_eq("rst_we", 32'(rom_we), 32'h0);
    check_eq("rst_wait", 32'(ifc.ioctl_wait), 32'h0);
    check_eq("rst_addr", 32'(rom_addr), 32'h0);
    check_eq("rst_data", 32'(rom_data), 32'h0);
    check_eq("rst_sum", 32'(checksum), 32'h0);
    check_eq("rst_done", 32'(load_done), 32'h0);
    check_eq("rst_err", 32'(load_error), 32'h0);
    check_eq("rst_grn", 32'(game_reset_n), 32'h0);
    reset_n = 1'b1;
    tick(2);

    // Nonzero index is ignored
    ifc.ioctl_index    = 8'h03;
    ifc.ioctl_download = 1'b1;
    tick(3);
    ifc.ioctl_addr = 25'h00000;
    ifc.ioctl_dout = 8'h77;
    ifc.ioctl_wr   = 1'b1;
    tick(1);
    ifc.ioctl_wr = 1'b0;
    check_eq("idx_wait", 32'(ifc.ioctl_wait), 32'h0);
    tick(3);
    check_eq("idx_pulses", 32'(pulses), 32'(exp_pulses));
    check_eq("idx_sum", 32'(checksum), 32'h0);
    check_eq("idx_done", 32'(load_done), 32'h0);
    ifc.ioctl_download = 1'b0;
    ifc.ioctl_index    = 8'h00;
    tick(2);

    // Complete image with zero checksum
    start_load();
    full_image(8'h00, 1'b0);
    ifc.ioctl_download = 1'b0;
    wait_status();
    check_eq("full_done", 32'(load_done), 32'h1);
    check_eq("full_err", 32'(load_error), 32'h0);
    check_eq("full_grn", 32'(game_reset_n), 32'h1);
    check_eq("full_sum", 32'(checksum), 32'(model_sum));
    check_eq("full_pulses", 32'(pulses), 32'(exp_pulses));
    tick(2);

    // Short download: flags cleared on arming, then an error
    start_load();
    check_eq("arm_grn", 32'(game_reset_n), 32'h0);
    check_eq("arm_done", 32'(load_done), 32'h0);
    for (int i = 0; i < 5; i++) send_byte(25'h00300 + 25'(i), 8'(i + 1), 1'b0);
    ifc.ioctl_download = 1'b0;
    wait_status();
    check_eq("short_err", 32'(load_error), 32'h1);
    check_eq("short_done", 32'(load_done), 32'h0);
    check_eq("short_grn", 32'(game_reset_n), 32'h0);
    check_eq("short_sum", 32'(checksum), 32'h0F);
    tick(2);

    // Extra byte past the image: counted and summed, never written
    start_load();
    full_image(8'h00, 1'b0);
    send_byte(25'h17000, 8'h5A, 1'b0);
    check_eq("extra_no_pulse", 32'(pulses), 32'(exp_pulses));
    check_eq("extra_sum", 32'(checksum), 32'h5A);
    ifc.ioctl_download = 1'b0;
    wait_status();
    check_eq("extra_err", 32'(load_error), 32'h1);
    check_eq("extra_grn", 32'(game_reset_n), 32'h0);
    tick(2);

    // Full-length image whose checksum is 0x5A
    start_load();
    full_image(8'h5A, 1'b0);
    ifc.ioctl_download = 1'b0;
    wait_status();
    check_eq("cks_sum", 32'(checksum), 32'h5A);
`ifdef QBERT_LOADER_CHECKSUM_EN
    check_eq("cks_err", 32'(load_error), 32'h1);
    check_eq("cks_done", 32'(load_done), 32'h0);
`else
    check_eq("cks_done", 32'(load_done), 32'h1);
    check_eq("cks_err", 32'(load_error), 32'h0);
`endif
    tick(2);

    // Reset pulsed during WRITE aborts the transfer
    start_load();
    send_byte(25'h00010, 8'h33, 1'b0);
    ifc.ioctl_addr = 25'h06005;
    ifc.ioctl_dout = 8'h44;
    ifc.ioctl_wr   = 1'b1;
    tick(1);
    ifc.ioctl_wr = 1'b0;
    check_eq("mid_we", 32'(rom_we), 32'b0010);
    check_eq("mid_addr", 32'(rom_addr), 32'h0005);
    reset_n = 1'b0;
    #1;
    check_eq("abort_we", 32'(rom_we), 32'h0);
    check_eq("abort_wait", 32'(ifc.ioctl_wait), 32'h0);
    check_eq("abort_sum", 32'(checksum), 32'h0);
    #1;
    reset_n = 1'b1;
    tick(3);
    // download level still high: must not re-arm
    ifc.ioctl_addr = 25'h00020;
    ifc.ioctl_dout = 8'h55;
    ifc.ioctl_wr   = 1'b1;
    tick(1);
    ifc.ioctl_wr = 1'b0;
    check_eq("noarm_wait", 32'(ifc.ioctl_wait), 32'h0);
    tick(4);
    check_eq("noarm_pulses", 32'(pulses), 32'(exp_pulses));
    check_eq("noarm_sum", 32'(checksum), 32'h0);
    ifc.ioctl_download = 1'b0;
    tick(2);

    // Next load completes; download drops during the final write
    start_load();
    full_image(8'h00, 1'b1);
    wait_status();
    check_eq("reload_done", 32'(load_done), 32'h1);
    check_eq("reload_err", 32'(load_error), 32'h0);
    check_eq("reload_grn", 32'(game_reset_n), 32'h1);
    tick(2);

    check_eq("total_pulses", 32'(pulses), 32'(exp_pulses));
    check_eq("pulse_len_bad", 32'(bad_len), 32'h0);
    check_eq("pulse_unstable", 32'(unstable), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qbert_rom_loader.md
QBERT_ROM_LOADER -- requirements
Module: qbert_rom_loader

Interface
REQ-001 Parameter WR_HOLD, default 2: number of clk_sys cycles each ROM write strobe is held high; legal range 1..7.
REQ-002 Parameter EXPECTED_SIZE, default 94208 (0x17000): byte count of a complete ROM image.
REQ-003 clk_sys  in  1  system clock; the only clock.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 ioctl_download  in  1  high while an HPS transfer is in progress.
REQ-006 ioctl_index  in  8  transfer index; only index 0 is accepted.
REQ-007 ioctl_wr  in  1  one-cycle byte-valid strobe.
REQ-008 ioctl_addr  in  25  byte address of ioctl_dout.
REQ-009 ioctl_dout  in  8  download byte.
REQ-010 ioctl_wait  out  1  backpressure; HPS shall not issue ioctl_wr while it is high.
REQ-011 rom_addr  out  16  region-relative write address.
REQ-012 rom_data  out  8  write data.
REQ-013 rom_we  out  4  one-hot write enables: [0] main CPU, [1] tiles, [2] sprites, [3] sound.
REQ-014 game_reset_n  out  1  low holds the video and sound boards in reset.
REQ-015 load_done  out  1  high after a successful load.
REQ-016 load_error  out  1  high after a failed load.
REQ-017 checksum  out  8  modulo-256 sum of the accepted bytes.

Function
REQ-018 The FSM SHALL have states IDLE, ARMED, WRITE, CHECK, DONE and ERROR.
REQ-019 IDLE→ARMED on ioctl_download=1 with ioctl_index=0; this transition clears the byte counter, checksum, load_done and load_error.
REQ-020 In ARMED, an ioctl_wr SHALL register addr and data and go to WRITE on the next cycle; ioctl_wait SHALL be high from the cycle after the strobe until the cycle after WRITE exits.
REQ-021 Address decode: 0x00000–0x05FFF→rom_we[0]; 0x06000–0x0DFFF→[1]; 0x0E000–0x15FFF→[2]; 0x16000–0x16FFF→[3]; rom_addr = ioctl_addr minus the region base, truncated to 16 bits.
REQ-022 WRITE SHALL hold rom_addr and rom_data stable and keep exactly one rom_we bit high for WR_HOLD cycles, then return to ARMED.
REQ-023 A byte at address ≥ 0x17000 SHALL be counted and summed but SHALL NOT assert any rom_we bit.
REQ-024 Each accepted byte SHALL increment the 17-bit byte counter (saturating at all-ones) and add to checksum (8-bit wrap).
REQ-025 ioctl_download falling while in ARMED→CHECK; if it falls during WRITE, the write SHALL complete and then go to CHECK.
REQ-026 CHECK (one cycle): counter == EXPECTED_SIZE→DONE, else→ERROR.
REQ-027 DONE sets load_done=1; ERROR sets load_error=1; both are sticky until the next ARMED entry and both return to IDLE in the same cycle.
REQ-028 game_reset_n = 0 from ARMED entry until DONE; it stays 0 after ERROR; it is 1 only after a successful load.
REQ-029 An ioctl_download with a nonzero index SHALL be ignored: no state change and no outputs affected.
REQ-030 rom_we SHALL be all-zero in every state except WRITE.

Reset
REQ-031 When reset_n=0, asynchronously: state=IDLE, ioctl_wait=0, rom_we=0, rom_addr=0, rom_data=0, checksum=0, counter=0, load_done=0, load_error=0, game_reset_n=0.
REQ-032 A reset asserted mid-transfer SHALL abort it; after release, the block waits in IDLE for the next rising edge of ioctl_download (a level still high at release does not re-arm).

Configuration
REQ-033 With QBERT_LOADER_CHECKSUM_EN defined, CHECK SHALL additionally require checksum == 8'h00 (the image carries a compensating pad byte); a mismatch goes to ERROR.
REQ-034 Without QBERT_LOADER_CHECKSUM_EN, checksum SHALL still be computed and output, but it SHALL NOT affect CHECK.

Verification
REQ-035 Full 94208-byte image, WR_HOLD=2 → 94208 writes, each rom_we pulse exactly 2 cycles; load_done=1; game_reset_n=1.
REQ-036 Bytes at 0x05FFF then 0x06000 → rom_we=0001 with rom_addr 0x5FFF, then rom_we=0010 with rom_addr 0x0000.
REQ-037 Download stopped at 1000 bytes → load_error=1, game_reset_n=0, load_done=0.
REQ-038 Extra byte at 0x17000 → no rom_we pulse; counter=94209; load_error=1.
REQ-039 reset_n pulsed low during a WRITE → rom_we=0 and ioctl_wait=0 immediately; the next load completes normally.
REQ-040 With QBERT_LOADER_CHECKSUM_EN, a full image whose checksum is 0x5A → load_error=1; without the macro, the same image → load_done=1.
